// File: rtl/fclass_unpack_pkg.sv
// Shared types and constants for the FPU operand unpacker: format codes,
// per-format field widths and the buffered flag/tag entry.
package fpu_unpack_pkg;

    localparam int FLEN  = 64;
    localparam int TAG_W = 5;

    typedef enum logic [1:0] {
        FMT_S   = 2'b00,
        FMT_D   = 2'b01,
        FMT_H   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    localparam int EXP_W_S  = 8;
    localparam int FRAC_W_S = 23;
    localparam int EXP_W_D  = 11;
    localparam int FRAC_W_D = 52;
    localparam int EXP_W_H  = 5;
    localparam int FRAC_W_H = 10;

    typedef struct packed {
        logic xs;
        logic xnan;
        logic xsnan;
        logic xsubnorm;
        logic xzero;
        logic xinf;
        logic xillegal;
    } flags_t;

    typedef struct packed {
        flags_t             flags;
        logic [TAG_W-1:0]   tag;
    } entry_t;

    // Common flag decode once the format-specific fields are reduced to these bits.
    function automatic flags_t classify(input logic sign, input logic exp_ones,
                                        input logic exp_zero, input logic frac_zero,
                                        input logic frac_msb);
        flags_t f;
        f          = '0;
        f.xs       = sign;
        f.xnan     = exp_ones & ~frac_zero;
        f.xsnan    = exp_ones & ~frac_zero & ~frac_msb;
        f.xinf     = exp_ones & frac_zero;
        f.xzero    = exp_zero & frac_zero;
        f.xsubnorm = exp_zero & ~frac_zero;
        return f;
    endfunction

endpackage

// File: rtl/fclass_unpack_if.sv
// Operand-in / flags-out handshake bundle for fclass_unpack.
interface fclass_unpack_if;
    import fpu_unpack_pkg::*;

    logic             InValid;
    logic             InReady;
    logic [FLEN-1:0]  X;
    logic [1:0]       Fmt;
    logic [TAG_W-1:0] InTag;
    logic             OutValid;
    logic             OutReady;
    logic             Xs;
    logic             XNaN;
    logic             XSNaN;
    logic             XSubnorm;
    logic             XZero;
    logic             XInf;
    logic             XIllegal;
    logic [TAG_W-1:0] OutTag;

    modport master (
        output InValid, X, Fmt, InTag, OutReady,
        input  InReady, OutValid, Xs, XNaN, XSNaN, XSubnorm, XZero, XInf, XIllegal, OutTag
    );

    modport slave (
        input  InValid, X, Fmt, InTag, OutReady,
        output InReady, OutValid, Xs, XNaN, XSNaN, XSubnorm, XZero, XInf, XIllegal, OutTag
    );

endinterface

// File: rtl/fclass_unpack_decode.sv
// Combinational operand classifier (funpack_decode). Define FUNPACK_NANBOX_EN
// to treat improperly NaN-boxed single/half operands as canonical quiet NaN.
module funpack_decode
    import fpu_unpack_pkg::*;
(
    input  logic [FLEN-1:0] x,
    input  logic [1:0]      fmt,
    output flags_t          flags
);

    logic s_boxed;
    logic h_boxed;

`ifdef FUNPACK_NANBOX_EN
    assign s_boxed = &x[FLEN-1:32];
    assign h_boxed = &x[FLEN-1:16];
`else
    assign s_boxed = 1'b1;
    assign h_boxed = 1'b1;
`endif

    always_comb begin
        flags = '0;
        case (fmt_e'(fmt))
            FMT_S: begin
                if (!s_boxed) begin
                    flags.xnan = 1'b1;
                end else begin
                    flags = classify(x[FRAC_W_S+EXP_W_S],
                                     &x[FRAC_W_S +: EXP_W_S], ~|x[FRAC_W_S +: EXP_W_S],
                                     ~|x[FRAC_W_S-1:0], x[FRAC_W_S-1]);
                end
            end
            FMT_D: begin
                flags = classify(x[FRAC_W_D+EXP_W_D],
                                 &x[FRAC_W_D +: EXP_W_D], ~|x[FRAC_W_D +: EXP_W_D],
                                 ~|x[FRAC_W_D-1:0], x[FRAC_W_D-1]);
            end
            FMT_H: begin
                if (!h_boxed) begin
                    flags.xnan = 1'b1;
                end else begin
                    flags = classify(x[FRAC_W_H+EXP_W_H],
                                     &x[FRAC_W_H +: EXP_W_H], ~|x[FRAC_W_H +: EXP_W_H],
                                     ~|x[FRAC_W_H-1:0], x[FRAC_W_H-1]);
                end
            end
            default: begin
                flags.xillegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fclass_unpack.sv
// Registered operand unpacker: decode feeds a two-entry flag/tag FIFO with
// valid/ready on both sides. Optional NaN-boxing check via FUNPACK_NANBOX_EN.
module fclass_unpack
    import fpu_unpack_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    fclass_unpack_if.slave io
);

    flags_t     dec_flags_p0;
    entry_t     in_entry_p0;
    entry_t     head_p1;
    entry_t     tail_p1;
    logic [1:0] cnt_p1;
    logic       in_ready;
    logic       vld_p1;
    logic       push;
    logic       pop;

    funpack_decode u_decode (
        .x     (io.X),
        .fmt   (io.Fmt),
        .flags (dec_flags_p0)
    );

    assign in_entry_p0 = '{flags: dec_flags_p0, tag: io.InTag};

    // Ready looks only at the registered count, so a full buffer never
    // accepts even when the consumer pops in the same cycle.
    assign in_ready = (cnt_p1 != 2'd2);
    assign vld_p1   = (cnt_p1 != 2'd0);
    assign push     = io.InValid & in_ready;
    assign pop      = vld_p1 & io.OutReady;

    // ---- p0 -> p1: buffer write / shift ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p1  <= 2'd0;
            head_p1 <= '0;
            tail_p1 <= '0;
        end else begin
            case (cnt_p1)
                2'd0: begin
                    if (push) begin
                        head_p1 <= in_entry_p0;
                        cnt_p1  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_p1 <= in_entry_p0;
                    end else if (push) begin
                        tail_p1 <= in_entry_p0;
                        cnt_p1  <= 2'd2;
                    end else if (pop) begin
                        cnt_p1  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_p1 <= tail_p1;
                        cnt_p1  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign io.InReady  = in_ready;
    assign io.OutValid = vld_p1;
    assign io.Xs       = vld_p1 & head_p1.flags.xs;
    assign io.XNaN     = vld_p1 & head_p1.flags.xnan;
    assign io.XSNaN    = vld_p1 & head_p1.flags.xsnan;
    assign io.XSubnorm = vld_p1 & head_p1.flags.xsubnorm;
    assign io.XZero    = vld_p1 & head_p1.flags.xzero;
    assign io.XInf     = vld_p1 & head_p1.flags.xinf;
    assign io.XIllegal = vld_p1 & head_p1.flags.xillegal;
    assign io.OutTag   = vld_p1 ? head_p1.tag : '0;

endmodule

// File: tb/tb_fclass_unpack.sv
// Directed bench for fclass_unpack: decode vector table plus hand-written
// back-pressure, streaming and asynchronous-reset sequences.
module tb_fclass_unpack;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    fclass_unpack_if bus ();

    fclass_unpack dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FUNPACK_NANBOX_EN
    localparam bit NB = 1'b1;
`else
    localparam bit NB = 1'b0;
`endif

    // Flag order: {Xs, XNaN, XSNaN, XSubnorm, XZero, XInf, XIllegal}
    typedef struct {
        logic [1:0]  fmt;
        logic [63:0] x;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [6:0] out_flags();
        return {bus.Xs, bus.XNaN, bus.XSNaN, bus.XSubnorm, bus.XZero, bus.XInf, bus.XIllegal};
    endfunction

    task automatic check_idle(input string name);
        check({name, "_valid"}, {63'd0, bus.OutValid}, 64'd0);
        check({name, "_ready"}, {63'd0, bus.InReady}, 64'd1);
        check({name, "_flags"}, {57'd0, out_flags()}, 64'd0);
        check({name, "_tag"},   {59'd0, bus.OutTag}, 64'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{2'b01, 64'h7FF0_0000_0000_0000, 7'b0000010};
        vecs[1]  = '{2'b00, 64'hFFFF_FFFF_7F80_0001, 7'b0110000};
        vecs[2]  = '{2'b00, 64'h0000_0000_7F80_0001, NB ? 7'b0100000 : 7'b0110000};
        vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_8001, 7'b1001000};
        vecs[4]  = '{2'b11, 64'h0123_4567_89AB_CDEF, 7'b0000001};
        vecs[5]  = '{2'b01, 64'h0000_0000_0000_0000, 7'b0000100};
        vecs[6]  = '{2'b01, 64'h8000_0000_0000_0000, 7'b1000100};
        vecs[7]  = '{2'b01, 64'h7FF8_0000_0000_0000, 7'b0100000};
        vecs[8]  = '{2'b01, 64'h3FF0_0000_0000_0000, 7'b0000000};
        vecs[9]  = '{2'b00, 64'hFFFF_FFFF_FF80_0000, 7'b1000010};
        vecs[10] = '{2'b00, 64'hFFFF_FFFF_7FC0_0000, 7'b0100000};
        vecs[11] = '{2'b10, 64'hFFFF_FFFF_FFFF_7C01, 7'b0110000};
        vecs[12] = '{2'b10, 64'hFFFF_FFFF_FFFF_FC00, 7'b1000010};
        vecs[13] = '{2'b10, 64'h0000_0000_0000_3C00, NB ? 7'b0100000 : 7'b0000000};
        vecs[14] = '{2'b00, 64'hFFFF_FFFF_0000_0001, 7'b0001000};
        vecs[15] = '{2'b11, 64'h7FF0_0000_0000_0000, 7'b0000001};
        vecs[16] = '{2'b10, 64'hFFFF_FFFF_FFFF_0000, 7'b0000100};

        reset_n      = 1'b0;
        bus.InValid  = 1'b0;
        bus.X        = '0;
        bus.Fmt      = 2'b00;
        bus.InTag    = '0;
        bus.OutReady = 1'b0;
        #2;
        check_idle("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Decode table: one operand at a time, visible the cycle after acceptance.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.InValid  = 1'b1;
            bus.Fmt      = vecs[i].fmt;
            bus.X        = vecs[i].x;
            bus.InTag    = 5'(i + 3);
            bus.OutReady = 1'b1;
            @(negedge clk);
            bus.InValid = 1'b0;
            check($sformatf("vec%0d_valid", i), {63'd0, bus.OutValid}, 64'd1);
            check($sformatf("vec%0d_flags", i), {57'd0, out_flags()}, {57'd0, vecs[i].exp});
            check($sformatf("vec%0d_tag", i), {59'd0, bus.OutTag}, 64'(i + 3));
        end
        @(negedge clk);
        check_idle("drained");

        // Back-pressure: three offers with OutReady low, only two accepted.
        bus.OutReady = 1'b0;
        bus.Fmt      = 2'b01;
        bus.X        = 64'h0;
        bus.InValid  = 1'b1;
        bus.InTag    = 5'd1;
        @(negedge clk);
        check("bp_ready1", {63'd0, bus.InReady}, 64'd1);
        check("bp_tag1a", {59'd0, bus.OutTag}, 64'd1);
        bus.InTag = 5'd2;
        @(negedge clk);
        check("bp_ready2", {63'd0, bus.InReady}, 64'd0);
        check("bp_tag1b", {59'd0, bus.OutTag}, 64'd1);
        bus.InTag = 5'd3;
        @(negedge clk);
        bus.InValid = 1'b0;
        check("bp_full_ready", {63'd0, bus.InReady}, 64'd0);
        check("bp_hold_valid", {63'd0, bus.OutValid}, 64'd1);
        check("bp_hold_tag", {59'd0, bus.OutTag}, 64'd1);
        check("bp_hold_flags", {57'd0, out_flags()}, 64'b0000100);
        bus.OutReady = 1'b1;
        @(negedge clk);
        check("bp_drain_tag2", {59'd0, bus.OutTag}, 64'd2);
        check("bp_drain_ready", {63'd0, bus.InReady}, 64'd1);
        @(negedge clk);
        check("bp_empty_valid", {63'd0, bus.OutValid}, 64'd0);
        check("bp_empty_tag", {59'd0, bus.OutTag}, 64'd0);

        // Streaming at count=1: push and pop together every cycle.
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1;
        bus.InTag    = 5'd10;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.InTag    = 5'(11 + k);
            bus.OutReady = 1'b1;
            check($sformatf("st%0d_valid", k), {63'd0, bus.OutValid}, 64'd1);
            check($sformatf("st%0d_tag", k), {59'd0, bus.OutTag}, 64'(10 + k));
            check($sformatf("st%0d_ready", k), {63'd0, bus.InReady}, 64'd1);
            @(negedge clk);
        end
        bus.InValid = 1'b0;
        check("st_last_tag", {59'd0, bus.OutTag}, 64'd18);
        @(negedge clk);
        check("st_empty_valid", {63'd0, bus.OutValid}, 64'd0);

        // Asynchronous reset with the buffer full.
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1;
        bus.Fmt      = 2'b11;
        bus.InTag    = 5'd21;
        @(negedge clk);
        bus.InTag = 5'd22;
        @(negedge clk);
        bus.InValid = 1'b0;
        check("ar_full_ready", {63'd0, bus.InReady}, 64'd0);
        check("ar_full_flags", {57'd0, out_flags()}, 64'b0000001);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        bus.OutReady = 1'b1;
        @(negedge clk);
        check("post_reset_valid", {63'd0, bus.OutValid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
